pipe_stage_reg: RTL

Parametrised pipeline-stage register for the RV32I core, the generalised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload bus and a control bus between two stages and adds a valid/ready handshake, stall back-pressure, synchronous flush and an optional 2-entry skid buffer. Control bits are forced to zero whenever the stage holds a bubble, so side-effecting signals such as regwen and wren can never fire from a killed slot.

---
 rtl/pipe_stage_reg.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer; control is forced to zero while the stage holds a bubble.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        count_o
);

    logic              m_v;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_v;
    logic              accept;
    logic              issue;

    assign accept = valid_i & ready_o & ~flush_i;
    assign issue  = m_v & ready_i;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] s_data;
            logic [CTRL_W-1:0] s_ctrl;

            // ready_o comes straight from a flop: no path from ready_i
            assign ready_o = ~s_v;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    m_v    <= 1'b0;
                    s_v    <= 1'b0;
                    m_data <= '0;
                    m_ctrl <= '0;
                    s_data <= '0;
                    s_ctrl <= '0;
                end else if (flush_i) begin
                    m_v <= 1'b0;
                    s_v <= 1'b0;
                end else if (s_v) begin
                    if (issue) begin
                        m_data <= s_data;
                        m_ctrl <= s_ctrl;
                        s_v    <= 1'b0;
                    end
                end else if (accept) begin
                    if (!m_v || issue) begin
                        m_v    <= 1'b1;
                        m_data <= data_i;
                        m_ctrl <= ctrl_i;
                    end else begin
                        s_v    <= 1'b1;
                        s_data <= data_i;
                        s_ctrl <= ctrl_i;
                    end
                end else if (issue) begin
                    m_v <= 1'b0;
                end
            end
        end else begin : g_single
            assign ready_o = ~m_v | ready_i;
            assign s_v     = 1'b0;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    m_v    <= 1'b0;
                    m_data <= '0;
                    m_ctrl <= '0;
                end else if (flush_i) begin
                    m_v <= 1'b0;
                end else if (accept) begin
                    m_v    <= 1'b1;
                    m_data <= data_i;
                    m_ctrl <= ctrl_i;
                end else if (issue) begin
                    m_v <= 1'b0;
                end
            end
        end
    endgenerate

    assign valid_o = m_v;
    assign data_o  = m_data;
    assign ctrl_o  = m_v ? m_ctrl : '0;
    assign count_o = {1'b0, m_v} + {1'b0, s_v};

endmodule
